// File: rtl/niosii_system_sysid_checker.sv
// niosii_system_sysid_checker
//
// Reads the system-ID slave's two words (word 0 = ID, word 1 = build
// timestamp). It compares them with build-time expected values and reports
// the result through a small CSR slave, so boot firmware can refuse to run on
// a mismatched FPGA image.
//
// A check starts on one of three triggers:
//   - the first cycle after reset release (AUTO_START),
//   - a software write of CONTROL.start,
//   - expiry of the periodic recheck counter (PERIOD, 0 = off).
// Any trigger that arrives while a check is running is dropped.
//
// Ports
//   clock, reset_n           single clock, synchronous active-low reset
//   sysid_address/read       single-cycle Avalon-MM read master to sysid
//   sysid_readdata           sysid data, valid READ_LATENCY cycles after read
//   avs_address/read/write/
//   avs_writedata            CSR slave (no waitrequest)
//   avs_readdata             registered CSR read data, valid one cycle after
//                            avs_read
//   check_ok                 high while the last completed check passed
//
// CSR map
//   0 STATUS  : [0] done, [1] id_ok, [2] ts_ok, [3] busy, [15:8] errcnt
//   1 CAP_ID  : last captured word 0
//   2 CAP_TS  : last captured word 1
//   3 CONTROL : write [0] start, [1] clear; reads return 0
module niosii_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h58D4_A4AC,
  parameter int unsigned READ_LATENCY       = 1,
  parameter bit          AUTO_START         = 1'b1,
  parameter logic [31:0] PERIOD             = 32'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        check_ok
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    WAIT_ID,
    RD_TS,
    WAIT_TS,
    COMPARE
  } state_t;

  // The wait counter is loaded with L-1 and captures when it reaches 0, so
  // the capture lands on the L-th cycle after the read strobe.
  localparam int unsigned WAIT_LAST  = (READ_LATENCY == 0) ? 0 : READ_LATENCY - 1;
  localparam logic [1:0]  WAIT_INIT  = WAIT_LAST[1:0];
  localparam bit          PER_EN     = (PERIOD != 32'd0);
  localparam logic [31:0] PER_RELOAD = PER_EN ? (PERIOD - 32'd1) : 32'd0;

  state_t      state_q,   state_d;
  logic [1:0]  wait_q,    wait_d;
  logic        auto_q,    auto_d;
  logic [31:0] per_q,     per_d;
  logic [31:0] cap_id_q,  cap_id_d;
  logic [31:0] cap_ts_q,  cap_ts_d;
  logic        done_q,    done_d;
  logic        id_ok_q,   id_ok_d;
  logic        ts_ok_q,   ts_ok_d;
  logic        ok_q,      ok_d;
  logic [7:0]  errcnt_q,  errcnt_d;
  logic [31:0] rdata_q,   rdata_d;

  logic        ctl_wr;
  logic        start_req;
  logic        clear_req;
  logic        per_fire;
  logic        idle;
  logic        trigger;
  logic        pass;
  logic        unused_wdata;

  assign unused_wdata = ^avs_writedata[31:2];

  assign ctl_wr    = avs_write && (avs_address == 2'd3);
  assign start_req = ctl_wr && avs_writedata[0];
  assign clear_req = ctl_wr && avs_writedata[1];
  assign idle      = (state_q == IDLE);
  assign per_fire  = PER_EN && (per_q == 32'd0);
  // Triggers are OR-ed, so simultaneous sources start a single check; while
  // busy they are simply ignored.
  assign trigger   = idle && (auto_q || start_req || per_fire);
  assign pass      = (cap_id_q == EXPECTED_ID) && (cap_ts_q == EXPECTED_TIMESTAMP);

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    auto_d   = 1'b0;
    per_d    = per_q;
    cap_id_d = cap_id_q;
    cap_ts_d = cap_ts_q;
    done_d   = done_q;
    id_ok_d  = id_ok_q;
    ts_ok_d  = ts_ok_q;
    ok_d     = ok_q;
    errcnt_d = errcnt_q;
    rdata_d  = rdata_q;

    // Periodic counter: reloads on every check start, counts only while idle.
    if (trigger) begin
      per_d = PER_RELOAD;
    end else if (idle && PER_EN) begin
      per_d = per_q - 32'd1;
    end

    // Clear is applied first so a same-cycle COMPARE below overrides the
    // flags and increments the already-cleared error count.
    if (clear_req) begin
      done_d   = 1'b0;
      id_ok_d  = 1'b0;
      ts_ok_d  = 1'b0;
      ok_d     = 1'b0;
      errcnt_d = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = RD_ID;
        end
      end
      RD_ID: begin
        if (READ_LATENCY == 0) begin
          cap_id_d = sysid_readdata;
          state_d  = RD_TS;
        end else begin
          wait_d  = WAIT_INIT;
          state_d = WAIT_ID;
        end
      end
      WAIT_ID: begin
        if (wait_q == 2'd0) begin
          cap_id_d = sysid_readdata;
          state_d  = RD_TS;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      RD_TS: begin
        if (READ_LATENCY == 0) begin
          cap_ts_d = sysid_readdata;
          state_d  = COMPARE;
        end else begin
          wait_d  = WAIT_INIT;
          state_d = WAIT_TS;
        end
      end
      WAIT_TS: begin
        if (wait_q == 2'd0) begin
          cap_ts_d = sysid_readdata;
          state_d  = COMPARE;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      COMPARE: begin
        done_d  = 1'b1;
        id_ok_d = (cap_id_q == EXPECTED_ID);
        ts_ok_d = (cap_ts_q == EXPECTED_TIMESTAMP);
        ok_d    = pass;
        if (!pass && (errcnt_d != 8'hFF)) begin
          errcnt_d = errcnt_d + 8'd1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (avs_read) begin
      unique case (avs_address)
        2'd0:    rdata_d = {16'h0000, errcnt_q, 4'h0, !idle, ts_ok_q, id_ok_q, done_q};
        2'd1:    rdata_d = cap_id_q;
        2'd2:    rdata_d = cap_ts_q;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      auto_q   <= AUTO_START;
      per_q    <= PER_RELOAD;
      cap_id_q <= '0;
      cap_ts_q <= '0;
      done_q   <= 1'b0;
      id_ok_q  <= 1'b0;
      ts_ok_q  <= 1'b0;
      ok_q     <= 1'b0;
      errcnt_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      auto_q   <= auto_d;
      per_q    <= per_d;
      cap_id_q <= cap_id_d;
      cap_ts_q <= cap_ts_d;
      done_q   <= done_d;
      id_ok_q  <= id_ok_d;
      ts_ok_q  <= ts_ok_d;
      ok_q     <= ok_d;
      errcnt_q <= errcnt_d;
      rdata_q  <= rdata_d;
    end
  end

  // Word select follows the phase: 0 through the ID read/wait (and in IDLE),
  // 1 from the timestamp read until the check returns to IDLE.
  assign sysid_read    = (state_q == RD_ID) || (state_q == RD_TS);
  assign sysid_address = (state_q == RD_TS) || (state_q == WAIT_TS) || (state_q == COMPARE);
  assign avs_readdata  = rdata_q;
  assign check_ok      = ok_q;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Bench for niosii_system_sysid_checker: four instances with different
// READ_LATENCY / AUTO_START / PERIOD settings share clock and reset, each
// with its own sysid slave model and CSR stimulus. A cycle-level model of the
// check schedule is compared against every instance on each cycle, and
// literal expectations pin key cycles and STATUS words.
module tb_niosii_system_sysid_checker;

  localparam int NI = 4;
  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'h58D4_A4AC;

  function automatic int lat_of(input int i);
    case (i)
      2:       return 0;
      3:       return 3;
      default: return 1;
    endcase
  endfunction
  function automatic int auto_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction
  function automatic int per_of(input int i);
    return (i == 1) ? 20 : 0;
  endfunction

  logic        clk = 1'b0;
  logic        reset_n;
  logic        b_saddr  [NI];
  logic        b_sread  [NI];
  logic [31:0] b_srdata [NI];
  logic [1:0]  b_addr   [NI];
  logic        b_rd     [NI];
  logic        b_wr     [NI];
  logic [31:0] b_wd     [NI];
  logic [31:0] b_rdata  [NI];
  logic        b_ok     [NI];

  logic [31:0] mem  [NI][2];
  logic [31:0] pipe [NI][3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    niosii_system_sysid_checker #(
      .EXPECTED_ID       (EXP_ID),
      .EXPECTED_TIMESTAMP(EXP_TS),
      .READ_LATENCY      (lat_of(g)),
      .AUTO_START        (auto_of(g) != 0),
      .PERIOD            (32'(per_of(g)))
    ) u_dut (
      .clock         (clk),
      .reset_n       (reset_n),
      .sysid_address (b_saddr[g]),
      .sysid_read    (b_sread[g]),
      .sysid_readdata(b_srdata[g]),
      .avs_address   (b_addr[g]),
      .avs_read      (b_rd[g]),
      .avs_write     (b_wr[g]),
      .avs_writedata (b_wd[g]),
      .avs_readdata  (b_rdata[g]),
      .check_ok      (b_ok[g])
    );
  end

  // Sysid slave: data for a read appears exactly L cycles later; any other
  // cycle carries a poison value so mistimed captures show up.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      pipe[i][0] <= b_sread[i] ? mem[i][b_saddr[i]] : 32'hDEAD_BEEF;
      pipe[i][1] <= pipe[i][0];
      pipe[i][2] <= pipe[i][1];
    end
  end
  always_comb begin
    for (int i = 0; i < NI; i++) begin
      b_srdata[i] = 32'hDEAD_BEEF;
      if (lat_of(i) == 0) begin
        if (b_sread[i]) b_srdata[i] = mem[i][b_saddr[i]];
      end else begin
        b_srdata[i] = pipe[i][lat_of(i) - 1];
      end
    end
  end

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int rel = 0;
  bit started = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: t = cycles since the trigger (0 = idle); a check lasts 3+2L
  // cycles, reads at t=1 and t=2+L, data lands L cycles after each read.
  int          m_t    [NI];
  int          m_idle [NI];
  bit          m_auto [NI];
  bit          m_done [NI], m_id [NI], m_ts [NI], m_ok [NI];
  int          m_err  [NI];
  logic [31:0] m_cid  [NI], m_cts [NI], m_sid [NI], m_sts [NI], m_rd [NI];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin : mdl
      int L, last;
      bit st, cl, busy, trig;
      L    = lat_of(i);
      last = 3 + 2 * L;
      if (!reset_n) begin
        m_t[i] = 0; m_idle[i] = 0; m_auto[i] = (auto_of(i) != 0);
        m_done[i] = 0; m_id[i] = 0; m_ts[i] = 0; m_ok[i] = 0; m_err[i] = 0;
        m_cid[i] = '0; m_cts[i] = '0; m_rd[i] = '0;
      end else begin
        st   = b_wr[i] && (b_addr[i] == 2'd3) && b_wd[i][0];
        cl   = b_wr[i] && (b_addr[i] == 2'd3) && b_wd[i][1];
        busy = (m_t[i] != 0);
        if (b_rd[i]) begin
          case (b_addr[i])
            2'd0:    m_rd[i] = 32'(m_done[i]) + 32'(m_id[i]) * 2 + 32'(m_ts[i]) * 4
                               + 32'(busy) * 8 + 32'(m_err[i]) * 256;
            2'd1:    m_rd[i] = m_cid[i];
            2'd2:    m_rd[i] = m_cts[i];
            default: m_rd[i] = '0;
          endcase
        end
        trig = !busy && (m_auto[i] || st || (per_of(i) != 0 && m_idle[i] + 1 == per_of(i)));
        m_auto[i] = 0;
        if (m_t[i] == 1)         m_sid[i] = mem[i][0];
        if (m_t[i] == 1 + L)     m_cid[i] = m_sid[i];
        if (m_t[i] == 2 + L)     m_sts[i] = mem[i][1];
        if (m_t[i] == 2 + 2 * L) m_cts[i] = m_sts[i];
        if (cl) begin
          m_done[i] = 0; m_id[i] = 0; m_ts[i] = 0; m_ok[i] = 0; m_err[i] = 0;
        end
        if (m_t[i] == last) begin
          m_done[i] = 1;
          m_id[i]   = (m_cid[i] == EXP_ID);
          m_ts[i]   = (m_cts[i] == EXP_TS);
          m_ok[i]   = m_id[i] && m_ts[i];
          if (!m_ok[i] && m_err[i] < 255) m_err[i]++;
        end
        if (busy)      m_t[i] = (m_t[i] == last) ? 0 : m_t[i] + 1;
        else if (trig) begin m_t[i] = 1; m_idle[i] = 0; end
        else           m_idle[i]++;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("i%0d sysid_read", i), 32'(b_sread[i]),
            32'(m_t[i] == 1 || m_t[i] == 2 + lat_of(i)));
        chk($sformatf("i%0d sysid_address", i), 32'(b_saddr[i]),
            32'(m_t[i] >= 2 + lat_of(i)));
        chk($sformatf("i%0d check_ok", i), 32'(b_ok[i]), 32'(m_ok[i]));
        chk($sformatf("i%0d avs_readdata", i), b_rdata[i], m_rd[i]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic goto(input int n);
    int guard;
    guard = 0;
    while (cyc < rel + n && guard < 1000) begin step(1); guard++; end
    if (cyc != rel + n) chk("goto cycle", 32'(cyc), 32'(rel + n));
  endtask

  task automatic csr_write(input int i, input logic [1:0] a, input logic [31:0] d);
    b_addr[i] = a; b_wd[i] = d; b_wr[i] = 1'b1;
    step(1);
    b_wr[i] = 1'b0; b_wd[i] = '0;
  endtask

  task automatic csr_read(input int i, input logic [1:0] a, output logic [31:0] d);
    b_addr[i] = a; b_rd[i] = 1'b1;
    step(1);
    b_rd[i] = 1'b0;
    d = b_rdata[i];
  endtask

  task automatic seq0;
    logic [31:0] v;
    step(1); chk("auto RD_ID read", 32'(b_sread[0]), 1); chk("auto RD_ID addr", 32'(b_saddr[0]), 0);
    step(1); chk("auto WAIT_ID read", 32'(b_sread[0]), 0);
    step(1); chk("auto RD_TS read", 32'(b_sread[0]), 1); chk("auto RD_TS addr", 32'(b_saddr[0]), 1);
    step(2); chk("ok at k+5", 32'(b_ok[0]), 0);
    step(1); chk("ok at k+6", 32'(b_ok[0]), 1);
    csr_read(0, 2'd0, v); chk("status pass", v, 32'h0000_0007);
    mem[0][0] = 32'h0000_0001;
    csr_write(0, 2'd3, 32'd1); step(8);
    csr_read(0, 2'd0, v); chk("status id fail", v, 32'h0000_0105);
    csr_read(0, 2'd1, v); chk("cap_id", v, 32'h0000_0001);
    chk("ok after fail", 32'(b_ok[0]), 0);
    csr_write(0, 2'd3, 32'd1); csr_write(0, 2'd3, 32'd1); step(8);
    csr_read(0, 2'd0, v); chk("start while busy dropped", v, 32'h0000_0205);
    csr_write(0, 2'd3, 32'd2);
    csr_read(0, 2'd0, v); chk("status after clear", v, 32'h0000_0000);
    for (int n = 0; n < 300; n++) begin csr_write(0, 2'd3, 32'd1); step(7); end
    csr_read(0, 2'd0, v); chk("errcnt saturates", v, 32'h0000_FF05);
    csr_write(0, 2'd3, 32'd1); step(4); csr_write(0, 2'd3, 32'd2); step(2);
    csr_read(0, 2'd0, v); chk("clear in COMPARE", v, 32'h0000_0105);
    csr_write(0, 2'd3, 32'd3); step(8);
    csr_read(0, 2'd0, v); chk("start+clear idle", v, 32'h0000_0105);
    mem[0][0] = 32'h0000_0000;
    csr_write(0, 2'd3, 32'd1); step(8);
    csr_read(0, 2'd0, v); chk("pass keeps errcnt", v, 32'h0000_0107);
    chk("ok after pass", 32'(b_ok[0]), 1);
  endtask

  task automatic seq1;
    logic [31:0] v;
    goto(19); chk("per idle k+19", 32'(b_sread[1]), 0);
    goto(20); chk("per 1st read", 32'(b_sread[1]), 1);
    goto(44); chk("per idle k+44", 32'(b_sread[1]), 0);
    goto(45); chk("per 2nd read", 32'(b_sread[1]), 1);
    goto(69); csr_write(1, 2'd3, 32'd1);
    chk("expiry+start RD_ID", 32'(b_sread[1]), 1);
    goto(72); chk("expiry+start RD_TS", 32'(b_sread[1]), 1); chk("expiry+start addr", 32'(b_saddr[1]), 1);
    goto(74); chk("no 2nd check a", 32'(b_sread[1]), 0);
    goto(75); chk("no 2nd check b", 32'(b_sread[1]), 0);
    goto(76); csr_read(1, 2'd0, v); chk("per status", v, 32'h0000_0007);
  endtask

  task automatic seq23;
    logic [31:0] v;
    csr_write(2, 2'd3, 32'd1);
    step(2); chk("L0 ok k+3", 32'(b_ok[2]), 0);
    step(1); chk("L0 ok k+4", 32'(b_ok[2]), 1);
    mem[2][1] = 32'h1234_5678;
    csr_write(2, 2'd3, 32'd1); step(6);
    csr_read(2, 2'd0, v); chk("L0 ts fail", v, 32'h0000_0103);
    csr_write(3, 2'd3, 32'd1);
    step(8); chk("L3 ok k+9", 32'(b_ok[3]), 0);
    step(1); chk("L3 ok k+10", 32'(b_ok[3]), 1);
    csr_read(3, 2'd2, v); chk("L3 cap_ts", v, EXP_TS);
  endtask

  initial begin
    logic [31:0] v;
    reset_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      b_addr[i] = '0; b_rd[i] = 1'b0; b_wr[i] = 1'b0; b_wd[i] = '0;
      mem[i][0] = EXP_ID; mem[i][1] = EXP_TS;
    end
    step(1);
    started = 1'b1;
    step(2);
    chk("reset check_ok", 32'(b_ok[0]), 0);
    chk("reset readdata", b_rdata[0], 0);
    chk("reset sysid_read", 32'(b_sread[0]), 0);
    reset_n = 1'b1;
    rel = cyc;
    fork
      seq0();
      seq1();
      seq23();
    join
    step(2);
    csr_write(0, 2'd3, 32'd1);
    step(3);
    chk("WAIT_TS addr before reset", 32'(b_saddr[0]), 1);
    reset_n = 1'b0;
    step(1);
    chk("mid reset sysid_read", 32'(b_sread[0]), 0);
    chk("mid reset sysid_address", 32'(b_saddr[0]), 0);
    chk("mid reset check_ok", 32'(b_ok[0]), 0);
    chk("mid reset readdata", b_rdata[0], 0);
    reset_n = 1'b1;
    step(5); chk("re-auto ok k+5", 32'(b_ok[0]), 0);
    step(1); chk("re-auto ok k+6", 32'(b_ok[0]), 1);
    csr_read(0, 2'd0, v); chk("re-auto status", v, 32'h0000_0007);
    step(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/niosii_system_sysid_checker.md
# niosII_system_sysid_checker

Sequencer that reads the system-ID slave's two words (ID at word 0, build timestamp at word 1) over a single-cycle Avalon-MM read port. It compares them against build-time expected values and reports the result to the Nios II through a small CSR slave. Checks are triggered by reset release, by software, or by a periodic timer. The block sits between the sysid control slave and the CPU data master, so boot firmware can refuse to run on a mismatched FPGA image.

## Interface

**Parameters**
- EXPECTED_ID, 32'h00000000: expected word 0.
- EXPECTED_TIMESTAMP, 32'h58D4A4AC: expected word 1.
- READ_LATENCY, 1: cycles from the sysid read cycle to valid sysid_readdata; legal range 0..3.
- AUTO_START, 1: when 1, a check starts on the first cycle after reset_n deasserts.
- PERIOD, 0: recheck interval in clocks; 0 disables periodic checks. Counter width is 32 bits.

**Ports**
- clock: in, 1. Single clock.
- reset_n: in, 1. Synchronous, active-low reset.
- sysid_address: out, 1. Word select to the sysid slave.
- sysid_read: out, 1. Read strobe.
- sysid_readdata: in, 32. Sysid read data.
- avs_address: in, 2. CSR word address.
- avs_read: in, 1. CSR read.
- avs_write: in, 1. CSR write.
- avs_writedata: in, 32. CSR write data.
- avs_readdata: out, 32. CSR read data, registered.
- check_ok: out, 1. Level output, high while the last completed check passed.

## Operation

**FSM states:** IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, COMPARE.
- IDLE -> RD_ID on a trigger. Triggers are: auto-start, a CSR start write, or periodic counter expiry.
- RD_ID: sysid_read=1, sysid_address=0.
  - READ_LATENCY=0: capture readdata into cap_id in this cycle, then go to RD_TS.
  - Otherwise go to WAIT_ID.
- WAIT_ID: hold READ_LATENCY cycles with sysid_read=0. Capture into cap_id on the last wait cycle, then go to RD_TS.
- RD_TS / WAIT_TS: same as RD_ID / WAIT_ID, with sysid_address=1 and capture into cap_ts.
- COMPARE: register the results, then return to IDLE.
  - id_ok = (cap_id == EXPECTED_ID)
  - ts_ok = (cap_ts == EXPECTED_TIMESTAMP)
  - done = 1
  - check_ok = id_ok & ts_ok
  - On failure, errcnt increments, saturating at 255.
- sysid_address holds its last value when sysid_read=0. It is 0 in IDLE.

**CSR map** (reads return data one cycle after avs_read):
- 0 STATUS: bit0 done, bit1 id_ok, bit2 ts_ok, bit3 busy (FSM not in IDLE), bits15:8 errcnt, other bits 0.
- 1 CAP_ID: last captured word 0.
- 2 CAP_TS: last captured word 1.
- 3 CONTROL, write-only; reads return 0.
  - bit0 = start.
  - bit1 = clear. Clear zeros done, id_ok, ts_ok, errcnt and check_ok.
- Writes to addresses 0..2 are ignored.

**Boundary rules:**
- Any trigger while busy is dropped; there is no queueing.
- Simultaneous triggers in one cycle start exactly one check.
- Periodic counter:
  - Reloads to PERIOD-1 whenever a check starts, whatever the trigger.
  - Counts down only in IDLE.
  - Fires at 0.
- Clear in the same cycle as COMPARE: COMPARE wins for done, id_ok, ts_ok and check_ok; errcnt is cleared and then the increment applies, giving 1 on failure.
- Start together with clear while idle: clear is applied and the check starts.
- Reset mid-check aborts the check; all state returns to reset values.

## Timing

**Reset values:** sysid_read=0, sysid_address=0, avs_readdata=0, check_ok=0, done=id_ok=ts_ok=0, errcnt=0, cap_id=cap_ts=0, FSM=IDLE.

**Check latency.** With the trigger sampled in IDLE at cycle k:
- RD_ID at k+1.
- RD_TS at k+2+L.
- COMPARE at k+3+2L.
- done, flags and check_ok visible at k+4+2L, where L=READ_LATENCY.
- For L=1 the result is visible at k+6.

**Auto-start:** the first cycle with reset_n=1 counts as cycle k.

**CSR timing:**
- avs_readdata is valid the cycle after avs_read.
- There is no waitrequest.
- The CSR port is always available, including while busy.

**Sysid port:** sysid_read is high for exactly one cycle per word; there are two pulses per check.

## Test plan

- Defaults, sysid model returns 0 at word 0 and 32'h58D4A4AC at word 1 (L=1), release reset -> read pulses at cycles 1 and 3 after release; at cycle 6 STATUS=32'h00000007 and check_ok=1.
- Model returns 32'h00000001 at word 0 -> after the check, STATUS=32'h00000105 (id_ok=0, errcnt=1), CAP_ID=1, check_ok=0.
- Write CONTROL=1 twice while busy -> only one check runs; a second CONTROL=1 after done runs another check; errcnt reaches 255 after 300 failing checks and holds.
- PERIOD=20, AUTO_START=0 -> first check starts after 20 idle cycles; subsequent checks are spaced 20 idle cycles apart; a CSR start write in the same cycle as expiry runs one check only.
- Deassert reset_n during WAIT_TS -> next cycle all outputs are at reset values; with AUTO_START=1 a fresh check completes 6 cycles after release.
- READ_LATENCY=0 and 3 -> done visible at k+4 and k+10 respectively; clear written in the COMPARE cycle of a failing check -> errcnt=1 and done=1.
